// File: rtl/axi_lite_master.sv
// AXI4-Lite initiator: turns a single-command request/response port into one
// AXI4-Lite write (AW/W/B) or read (AR/R) at a time, with a wait-state abort timer.
module axi_lite_master #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic                  rsp_timeout,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR_REQ  = 3'd1;
  localparam logic [2:0] S_WR_RESP = 3'd2;
  localparam logic [2:0] S_RD_REQ  = 3'd3;
  localparam logic [2:0] S_RD_RESP = 3'd4;
  localparam logic [2:0] S_RSP     = 3'd5;

  // Counter is wide enough to hold TIMEOUT itself: a REQ->RESP step taken on the
  // last count pushes it one past TO_LAST, and the >= compare still aborts.
  localparam int              CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0]   TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [2:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [1:0]            resp_q, resp_d;
  logic awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
  logic bready_q, bready_d, rready_q, rready_d;
  logic aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic rsp_valid_q, rsp_valid_d, timeout_q, timeout_d;
  logic aw_hs, w_hs, timeout_hit, abort;

  assign aw_hs       = awvalid_q & m_axi_awready;
  assign w_hs        = wvalid_q & m_axi_wready;
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q >= TO_LAST);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CW'(1);
    awaddr_d    = awaddr_q;
    araddr_d    = araddr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    resp_d      = resp_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    arvalid_d   = arvalid_q;
    bready_d    = bready_q;
    rready_d    = rready_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    rsp_valid_d = rsp_valid_q;
    timeout_d   = timeout_q;
    abort       = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (cmd_valid) begin
          timeout_d = 1'b0;
          if (cmd_write) begin
            awaddr_d  = cmd_addr;
            wdata_d   = cmd_wdata;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            state_d   = S_WR_REQ;
          end else begin
            araddr_d  = cmd_addr;
            arvalid_d = 1'b1;
            state_d   = S_RD_REQ;
          end
        end
      end
      S_WR_REQ: begin
        if (aw_hs) begin awvalid_d = 1'b0; aw_done_d = 1'b1; end
        if (w_hs)  begin wvalid_d  = 1'b0; w_done_d  = 1'b1; end
        if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
          bready_d = 1'b1;
          state_d  = S_WR_RESP;
        end else if (timeout_hit) abort = 1'b1;
      end
      S_WR_RESP: begin
        if (m_axi_bvalid) begin
          bready_d    = 1'b0;
          resp_d      = m_axi_bresp;
          rdata_d     = '0;
          rsp_valid_d = 1'b1;
          state_d     = S_RSP;
        end else if (timeout_hit) abort = 1'b1;
      end
      S_RD_REQ: begin
        if (m_axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RD_RESP;
        end else if (timeout_hit) abort = 1'b1;
      end
      S_RD_RESP: begin
        if (m_axi_rvalid) begin
          rready_d    = 1'b0;
          resp_d      = m_axi_rresp;
          rdata_d     = m_axi_rdata;
          rsp_valid_d = 1'b1;
          state_d     = S_RSP;
        end else if (timeout_hit) abort = 1'b1;
      end
      S_RSP: begin
        cnt_d = cnt_q;
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Debug abort: abandon the bus mid-protocol and report a SLVERR-style timeout.
    if (abort) begin
      awvalid_d   = 1'b0;
      wvalid_d    = 1'b0;
      arvalid_d   = 1'b0;
      bready_d    = 1'b0;
      rready_d    = 1'b0;
      rsp_valid_d = 1'b1;
      timeout_d   = 1'b1;
      resp_d      = 2'b10;
      rdata_d     = '0;
      state_d     = S_RSP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      awaddr_q    <= '0;
      araddr_q    <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      resp_q      <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      rready_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      awaddr_q    <= awaddr_d;
      araddr_q    <= araddr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      resp_q      <= resp_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      arvalid_q   <= arvalid_d;
      bready_q    <= bready_d;
      rready_q    <= rready_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      rsp_valid_q <= rsp_valid_d;
      timeout_q   <= timeout_d;
    end
  end

  assign cmd_ready     = (state_q == S_IDLE) & ~rst;
  assign busy          = (state_q != S_IDLE);
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rdata_q;
  assign rsp_resp      = resp_q;
  assign rsp_timeout   = timeout_q;
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;
endmodule

// File: tb/tb_axi_lite_master.sv
// Scoreboard bench for axi_lite_master: randomized commands against a reactive
// AXI-Lite slave, expected responses computed from a word-memory model.
module tb_axi_lite_master;
  logic        clk, rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [3:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_timeout, busy;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [3:0]  m_axi_awaddr, m_axi_araddr;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic [31:0] m_axi_wdata, m_axi_rdata;
  logic [1:0]  m_axi_bresp, m_axi_rresp;
  logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic        m_axi_rvalid, m_axi_rready;

  axi_lite_master #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout), .busy(busy),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready)
  );

  typedef struct { bit hang; int aw_dly, w_dly, b_dly, ar_dly, r_dly; logic [1:0] resp; } plan_t;
  typedef struct { bit wr; logic [3:0] addr; logic [31:0] wdata, rdata; logic [1:0] resp; bit to; int lat; } exp_t;

  plan_t       plan_q[$];
  exp_t        exp_q[$];
  logic [31:0] model[4];
  logic [31:0] smem[4];
  int          n_chk = 0, n_pass = 0;
  int          cyc = 0, acc_cyc = 0;
  int          n_aw, n_w, n_b, n_ar, n_r;
  bit          aw_ev, w_ev, b_ev, ar_ev, r_ev, hold;
  logic [3:0]  cap_awaddr, cap_araddr;
  logic [31:0] cap_wdata;

  initial begin clk = 0; forever #5 clk = ~clk; end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Handshake observer: sampled on the active edge, before the DUT updates.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      aw_ev = m_axi_awvalid && m_axi_awready;
      w_ev  = m_axi_wvalid && m_axi_wready;
      b_ev  = m_axi_bvalid && m_axi_bready;
      ar_ev = m_axi_arvalid && m_axi_arready;
      r_ev  = m_axi_rvalid && m_axi_rready;
      if (rst) begin
        {aw_ev, w_ev, b_ev, ar_ev, r_ev} = '0;
        n_aw = 0; n_w = 0; n_b = 0; n_ar = 0; n_r = 0;
      end else begin
        if (aw_ev) begin n_aw++; cap_awaddr = m_axi_awaddr; end
        if (w_ev)  begin n_w++;  cap_wdata  = m_axi_wdata;  end
        if (ar_ev) begin n_ar++; cap_araddr = m_axi_araddr; end
        if (b_ev) n_b++;
        if (r_ev) n_r++;
      end
    end
  end

  // Reactive slave: follows the per-transaction plan, backed by smem.
  initial begin
    plan_t p; bit act, aw_d, w_d, ar_d; int aw_n, w_n, b_n, ar_n, r_n;
    act = 0; aw_d = 0; w_d = 0; ar_d = 0; aw_n = 0; w_n = 0; b_n = 0; ar_n = 0; r_n = 0;
    p = '{default: 0};
    m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
    m_axi_bvalid = 0; m_axi_bresp = 0; m_axi_rvalid = 0; m_axi_rresp = 0; m_axi_rdata = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        act = 0; m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
        m_axi_bvalid = 0; m_axi_rvalid = 0;
        continue;
      end
      if (aw_ev) aw_d = 1;
      if (w_ev)  w_d  = 1;
      if (ar_ev) ar_d = 1;
      if (b_ev) begin m_axi_bvalid = 0; act = 0; end
      if (r_ev) begin m_axi_rvalid = 0; act = 0; end
      if (!act && (m_axi_awvalid || m_axi_arvalid) && plan_q.size() > 0) begin
        p = plan_q.pop_front(); act = 1; aw_d = 0; w_d = 0; ar_d = 0;
        aw_n = p.aw_dly; w_n = p.w_dly; b_n = p.b_dly; ar_n = p.ar_dly; r_n = p.r_dly;
      end
      if (act && aw_d && w_d && !m_axi_bvalid) begin
        if (b_n == 0) begin
          m_axi_bvalid = 1; m_axi_bresp = p.resp; smem[cap_awaddr[3:2]] = cap_wdata;
        end else b_n--;
      end
      if (act && ar_d && !m_axi_rvalid) begin
        if (r_n == 0) begin
          m_axi_rvalid = 1; m_axi_rresp = p.resp; m_axi_rdata = smem[cap_araddr[3:2]];
        end else r_n--;
      end
      // Readiness persists after a handshake so a stuck valid shows up as a repeat.
      m_axi_awready = act && !p.hang && m_axi_awvalid && (aw_d || aw_n == 0);
      m_axi_wready  = act && !p.hang && m_axi_wvalid  && (w_d  || w_n  == 0);
      m_axi_arready = act && !p.hang && m_axi_arvalid && (ar_d || ar_n == 0);
      if (act && m_axi_awvalid && aw_n > 0) aw_n--;
      if (act && m_axi_wvalid  && w_n  > 0) w_n--;
      if (act && m_axi_arvalid && ar_n > 0) ar_n--;
    end
  end

  // Monitor: drives rsp_ready and scores each response handshake.
  initial begin
    exp_t e; bit prev_v;
    prev_v = 0; rsp_ready = 0;
    forever begin
      @(negedge clk);
      rsp_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
      if (rst) begin prev_v = 0; continue; end
      if (rsp_valid && !prev_v && exp_q.size() > 0 && exp_q[0].lat >= 0)
        chk("latency", 64'(cyc - acc_cyc), 64'(exp_q[0].lat));
      prev_v = rsp_valid;
      if (rsp_valid && rsp_ready) begin
        chk("rsp_expected", 64'(exp_q.size() > 0), 64'(1));
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
          chk("rsp_resp", 64'(rsp_resp), 64'(e.resp));
          chk("rsp_timeout", 64'(rsp_timeout), 64'(e.to));
          if (e.to)
            chk("abort_valids", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready}), 64'(0));
          else begin
            chk("hs_counts", 64'({8'(n_aw), 8'(n_w), 8'(n_b), 8'(n_ar), 8'(n_r)}),
                e.wr ? 64'h01_01_01_00_00 : 64'h00_00_00_01_01);
            if (e.wr) chk("wr_addr_data", 64'({cap_awaddr, cap_wdata}), 64'({e.addr, e.wdata}));
            else      chk("rd_addr", 64'(cap_araddr), 64'(e.addr));
          end
        end
        n_aw = 0; n_w = 0; n_b = 0; n_ar = 0; n_r = 0;
      end
    end
  end

  function automatic plan_t mkplan(int aw, int w, int b, int ar, int r, logic [1:0] resp, bit hang);
    plan_t p;
    p.aw_dly = aw; p.w_dly = w; p.b_dly = b; p.ar_dly = ar; p.r_dly = r; p.resp = resp; p.hang = hang;
    return p;
  endfunction

  task automatic issue(input bit wr, input logic [3:0] a, input logic [31:0] d,
                       input plan_t p, input int lat, input bit track);
    exp_t e; int t;
    e.wr = wr; e.addr = a; e.wdata = d; e.to = p.hang; e.lat = lat;
    e.resp  = p.hang ? 2'b10 : p.resp;
    e.rdata = (wr || p.hang) ? 32'h0 : model[a[3:2]];
    if (wr && !p.hang && track) model[a[3:2]] = d;
    plan_q.push_back(p);
    if (track) exp_q.push_back(e);
    @(negedge clk);
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    t = 0;
    while (!cmd_ready && t < 300) begin @(negedge clk); t++; end
    chk("cmd_accept", 64'(cmd_ready), 64'(1));
    @(negedge clk);
    acc_cyc = cyc;
    cmd_valid = 0; cmd_addr = 4'($urandom); cmd_wdata = $urandom;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() > 0 && t < 500) begin @(negedge clk); t++; end
    chk("drain", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic chk_idle_outputs(input string nm);
    chk({nm, "_ctl"}, 64'({cmd_ready, busy, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid,
                           m_axi_bready, m_axi_rready, rsp_valid, rsp_timeout}), 64'(0));
    chk({nm, "_data"}, {m_axi_awaddr, m_axi_araddr, m_axi_wdata[15:0]}, 64'(0));
    chk({nm, "_rsp"}, {m_axi_wdata[31:16], rsp_rdata, 14'h0, rsp_resp}, 64'(0));
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1;
    plan_q.delete(); exp_q.delete();
    @(negedge clk);
    chk_idle_outputs("reset");
    @(negedge clk); rst = 0;
  endtask

  initial begin
    int t; bit seen;
    rst = 1; hold = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0;
    for (int i = 0; i < 4; i++) begin model[i] = 0; smem[i] = 0; end
    repeat (2) @(negedge clk);
    chk_idle_outputs("por");
    rst = 0;
    @(negedge clk);
    chk("idle_ready", 64'({cmd_ready, busy}), 64'(2'b10));

    // Zero-wait write and read: fixed 2-edge accept-to-response latency.
    issue(1, 4'h4, 32'h0000_00A5, mkplan(0, 0, 0, 0, 0, 2'b00, 0), 2, 1);
    drain();
    issue(1, 4'h8, 32'hDEAD_BEEF, mkplan(0, 0, 0, 0, 0, 2'b00, 0), 2, 1);
    issue(0, 4'h8, 32'h0, mkplan(0, 0, 0, 0, 3, 2'b00, 0), -1, 1);
    issue(0, 4'h4, 32'h0, mkplan(0, 0, 0, 0, 0, 2'b00, 0), 2, 1);
    // Skewed AW/W in both orders, then error responses passed through.
    issue(1, 4'hC, 32'h1234_5678, mkplan(0, 4, 0, 0, 0, 2'b00, 0), -1, 1);
    issue(1, 4'h0, 32'h8765_4321, mkplan(4, 0, 1, 0, 0, 2'b00, 0), -1, 1);
    issue(1, 4'h4, 32'hCAFE_F00D, mkplan(1, 2, 2, 0, 0, 2'b11, 0), -1, 1);
    issue(0, 4'hC, 32'h0, mkplan(0, 0, 0, 2, 1, 2'b10, 0), -1, 1);
    drain();

    for (int i = 0; i < 40; i++) begin
      issue(1'($urandom), {2'($urandom), 2'b00}, $urandom,
            mkplan(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 2'($urandom), 0), -1, 1);
    end
    drain();

    // Dead slave: abort after 16 cycles in the request state.
    issue(0, 4'h8, 32'h0, mkplan(0, 0, 0, 0, 0, 2'b00, 1), 16, 1);
    drain();
    do_reset();
    issue(1, 4'h0, 32'h5555_AAAA, mkplan(0, 0, 0, 0, 0, 2'b00, 1), 16, 1);
    drain();
    do_reset();

    // Reset while waiting on B: no response may follow.
    issue(1, 4'h4, 32'hBAD0_BAD0, mkplan(0, 0, 8, 0, 0, 2'b00, 0), -1, 0);
    t = 0;
    while (!m_axi_bready && t < 50) begin @(negedge clk); t++; end
    chk("bready_seen", 64'(m_axi_bready), 64'(1));
    do_reset();
    seen = 0;
    repeat (12) begin @(negedge clk); seen |= rsp_valid; end
    chk("no_rsp_after_reset", 64'({seen, cmd_ready, busy}), 64'(3'b010));

    // Held rsp_ready: response and back-pressure on cmd_ready must persist.
    hold = 1;
    issue(0, 4'h4, 32'h0, mkplan(0, 0, 0, 0, 0, 2'b00, 0), 2, 1);
    t = 0;
    while (!rsp_valid && t < 50) begin @(negedge clk); t++; end
    repeat (5) begin
      @(negedge clk);
      chk("hold_rsp", 64'({rsp_valid, cmd_ready, busy}), 64'(3'b101));
    end
    hold = 0;
    drain();
    issue(0, 4'h8, 32'h0, mkplan(0, 0, 0, 1, 0, 2'b00, 0), -1, 1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d passed so far", n_pass, n_chk);
    $fatal(1, "watchdog");
  end
endmodule
